i2c_slave_rx_ack: RTL and testbench
===================================

# i2c_slave_rx_ack

Slave-side receive assembler and acknowledge generator, directly downstream of the slave bit reader. It consumes the reader's serial bit stream (`data`/`load`/`finish`) and assembles bits MSB-first into a byte. On the address byte it performs the 7-bit address compare and captures R/W. It then drives ACK or NACK on SDA for the 9th SCL clock and reports completion to the slave controller FSM.

## Interface
Parameters:
- `SLAVE_ADDR`, 7'h50: own 7-bit address.

Ports:
- `clock` in 1: system clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `go` in 1: enable. Low forces IDLE, clears the bit count and releases SDA.
- `addr_phase` in 1: the current byte is the address byte. Sampled at byte completion.
- `ack_en` in 1: controller permits ACK of a data byte. Sampled at byte completion.
- `bit_data` in 1: bit from the reader.
- `bit_load` in 1: one-cycle strobe; `bit_data` is valid.
- `byte_finish` in 1: reader's 8th-bit indication; coincides with the 8th `bit_load`.
- `scl` in 1: SCL line level.
- `rx_byte` out 8: assembled byte. Held until the next completion.
- `rx_valid` out 1: one-cycle pulse at byte completion.
- `addr_match` out 1: address byte matched. Held until the next address byte or until `go` deasserts.
- `rw` out 1: bit 0 of the last matched address byte.
- `sda_oe` out 1: 1 pulls SDA low (ACK drive). The pad releases SDA when 0.
- `ack_done` out 1: one-cycle pulse after the 9th SCL falling edge.
- `nack` out 1: valid with `ack_done`; 1 if NACK was given.
- `frame_error` out 1: sticky. Set when `byte_finish` arrives with the bit count not equal to 7. Cleared when `go` deasserts.

## Operation
- **SCL edge detection.** 2-bit history register `{prev, scl}`. Rising edge when the history is `01`; falling edge when it is `10`.
- **Bit counter.** 3-bit counter, increments on each `bit_load`. Shift register: `sh <= {sh[6:0], bit_data}` on `bit_load`.
- **Byte completion.** `bit_load && byte_finish` in SHIFT:
  - `rx_byte <= {sh[6:0], bit_data}`, `rx_valid` pulses next cycle, counter clears.
  - If the count was not 7: set `frame_error` and return to SHIFT with no ACK.
- **ACK decision** at completion:
  - Address phase: ACK iff `byte[7:1] == SLAVE_ADDR`. `addr_match` is updated with the compare result; `rw <= byte[0]` only on a match.
  - Data phase: ACK iff `ack_en && addr_match`.
- **FSM states:**
  - IDLE: wait for `go`, then go to SHIFT.
  - SHIFT: go to ACK_SETUP on a clean byte completion.
  - ACK_SETUP: on the SCL falling edge, `sda_oe <= ack`; go to ACK_HIGH.
  - ACK_HIGH: on the SCL rising edge, go to ACK_RELEASE.
  - ACK_RELEASE: on the SCL falling edge, `sda_oe <= 0`, pulse `ack_done` with `nack = ~ack`; go to SHIFT.
- **NACK path.** Identical state sequence with `sda_oe` held at 0.
- **`go` low in any state.** Next clock: IDLE, `sda_oe = 0`, counter 0, `addr_match = 0`, `frame_error = 0`. `rx_byte` is retained.
- **`bit_load` in ACK states.** Ignored, not counted.

## Timing
- **Reset values:** `rx_byte` 8'h00; `rx_valid`, `addr_match`, `rw`, `sda_oe`, `ack_done`, `nack`, `frame_error` all 0. FSM in IDLE, counter 0, SCL history 2'b00.
- **`rx_valid`:** 1 clock after the completing `bit_load`.
- **`sda_oe` assertion:** 1 clock after the SCL falling edge is detected. This is inside SCL low, before the 9th rising edge.
- **`sda_oe` release and `ack_done`:** release 1 clock after the 9th-clock falling edge is detected; `ack_done` pulses in the same cycle.
- **Simultaneous events:**
  - Completion and an SCL falling edge in the same cycle: the edge is not consumed; ACK_SETUP waits for the next falling edge.
  - `go` deassertion has priority over all events.
- **Completion coincides with `bit_load`:** `frame_error` and `rx_valid` can both assert on the same byte.

## Configuration
- **`I2C_SLAVE_GENERAL_CALL_EN` defined:** an address byte 8'h00 also matches. `addr_match` = 1, `rw` = 0, ACK given.
- **Not defined:** only `SLAVE_ADDR` matches; 8'h00 is NACKed with `addr_match` = 0.

## Test plan
- **Address match.** `addr_phase` = 1, bits 1010_0000 (8'hA0, `SLAVE_ADDR` 7'h50) -> `rx_byte` 8'hA0, `rx_valid` pulse, `addr_match` 1, `rw` 0. `sda_oe` is high from the 8th-clock SCL fall until the 9th-clock SCL fall; then `ack_done` with `nack` 0.
- **Address mismatch.** Bits 8'hA3 -> `addr_match` 0, `sda_oe` never 1, `ack_done` with `nack` 1.
- **Data byte.** After a matched address, `addr_phase` 0, `ack_en` 1, bits 8'h3C -> `rx_byte` 8'h3C, ACK driven. Repeat with `ack_en` 0 and 8'hFF -> `nack` 1.
- **Short frame.** `byte_finish` with the 5th `bit_load` -> `frame_error` 1, no `sda_oe`, FSM back in SHIFT. Then deassert `go` -> `frame_error` 0.
- **Abort during ACK.** Deassert `go` while in ACK_HIGH with `sda_oe` 1 -> next clock `sda_oe` 0, IDLE, no `ack_done`. Separately, assert `reset_n` low mid-byte -> all outputs at reset values immediately.
- **General call.** Address 8'h00 -> `addr_match` 1 with `I2C_SLAVE_GENERAL_CALL_EN` defined; `nack` 1 without it.

Source files
------------

// File: rtl/i2c_slave_rx_ack_if.sv
// Bus between the I2C slave bit reader / controller and the receive assembler.
// The slave modport is the assembler's view; master is the driving side.
interface i2c_slave_rx_ack_if;
    logic       go;
    logic       addr_phase;
    logic       ack_en;
    logic       bit_data;
    logic       bit_load;
    logic       byte_finish;
    logic       scl;
    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       addr_match;
    logic       rw;
    logic       sda_oe;
    logic       ack_done;
    logic       nack;
    logic       frame_error;

    modport slave (
        input  go, addr_phase, ack_en, bit_data, bit_load, byte_finish, scl,
        output rx_byte, rx_valid, addr_match, rw, sda_oe, ack_done, nack, frame_error
    );

    modport master (
        output go, addr_phase, ack_en, bit_data, bit_load, byte_finish, scl,
        input  rx_byte, rx_valid, addr_match, rw, sda_oe, ack_done, nack, frame_error
    );
endinterface

// File: rtl/i2c_slave_rx_ack.sv
// I2C slave receive assembler: MSB-first byte assembly, address compare, ACK/NACK on SDA.
// Define I2C_SLAVE_GENERAL_CALL_EN to also accept the general-call address byte 8'h00.
module i2c_slave_rx_ack #(
    parameter logic [6:0] SLAVE_ADDR = 7'h50
) (
    input  logic               clock,
    input  logic               reset_n,
    i2c_slave_rx_ack_if.slave  bus
);
    typedef enum logic [2:0] {IDLE, SHIFT, ACK_SETUP, ACK_HIGH, ACK_RELEASE} state_t;

    state_t     state_q;
    logic [1:0] scl_hist_q;
    logic [2:0] cnt_q;
    logic [6:0] sh_q;
    logic [7:0] rx_byte_q;
    logic       rx_valid_q, addr_match_q, rw_q, sda_oe_q, ack_done_q, nack_q, frame_error_q;
    logic       ack_q;

    logic       scl_rise, scl_fall, addr_hit;
    logic [7:0] rx_byte_d;

    assign scl_rise  = (scl_hist_q == 2'b01);
    assign scl_fall  = (scl_hist_q == 2'b10);
    assign rx_byte_d = {sh_q, bus.bit_data};

`ifdef I2C_SLAVE_GENERAL_CALL_EN
    assign addr_hit = (rx_byte_d[7:1] == SLAVE_ADDR) || (rx_byte_d == 8'h00);
`else
    assign addr_hit = (rx_byte_d[7:1] == SLAVE_ADDR);
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            scl_hist_q    <= 2'b00;
            cnt_q         <= 3'd0;
            sh_q          <= 7'd0;
            rx_byte_q     <= 8'h00;
            rx_valid_q    <= 1'b0;
            addr_match_q  <= 1'b0;
            rw_q          <= 1'b0;
            sda_oe_q      <= 1'b0;
            ack_done_q    <= 1'b0;
            nack_q        <= 1'b0;
            frame_error_q <= 1'b0;
            ack_q         <= 1'b0;
        end else begin
            scl_hist_q <= {scl_hist_q[0], bus.scl};
            rx_valid_q <= 1'b0;
            ack_done_q <= 1'b0;
            if (!bus.go) begin
                state_q       <= IDLE;
                sda_oe_q      <= 1'b0;
                cnt_q         <= 3'd0;
                addr_match_q  <= 1'b0;
                frame_error_q <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: state_q <= SHIFT;
                    SHIFT: if (bus.bit_load) begin
                        sh_q  <= rx_byte_d[6:0];
                        cnt_q <= cnt_q + 3'd1;
                        if (bus.byte_finish) begin
                            rx_byte_q  <= rx_byte_d;
                            rx_valid_q <= 1'b1;
                            cnt_q      <= 3'd0;
                            // A short byte is reported but never acknowledged.
                            if (cnt_q != 3'd7) begin
                                frame_error_q <= 1'b1;
                            end else begin
                                state_q <= ACK_SETUP;
                                if (bus.addr_phase) begin
                                    addr_match_q <= addr_hit;
                                    ack_q        <= addr_hit;
                                    if (addr_hit) rw_q <= rx_byte_d[0];
                                end else begin
                                    ack_q <= bus.ack_en && addr_match_q;
                                end
                            end
                        end
                    end
                    // A fall coincident with completion is seen while still in SHIFT, so it is skipped.
                    ACK_SETUP: if (scl_fall) begin
                        sda_oe_q <= ack_q;
                        state_q  <= ACK_HIGH;
                    end
                    ACK_HIGH: if (scl_rise) state_q <= ACK_RELEASE;
                    ACK_RELEASE: if (scl_fall) begin
                        sda_oe_q   <= 1'b0;
                        ack_done_q <= 1'b1;
                        nack_q     <= ~ack_q;
                        state_q    <= SHIFT;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign bus.rx_byte     = rx_byte_q;
    assign bus.rx_valid    = rx_valid_q;
    assign bus.addr_match  = addr_match_q;
    assign bus.rw          = rw_q;
    assign bus.sda_oe      = sda_oe_q;
    assign bus.ack_done    = ack_done_q;
    assign bus.nack        = nack_q;
    assign bus.frame_error = frame_error_q;
endmodule

// File: tb/tb_i2c_slave_rx_ack.sv
// Bench for i2c_slave_rx_ack: vector table of bytes plus hand-written corner sequences,
// with rx/ack scoreboard queues popped on rx_valid and ack_done pulses.
module tb_i2c_slave_rx_ack;
    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    i2c_slave_rx_ack_if bus ();
    i2c_slave_rx_ack #(.SLAVE_ADDR(7'h50)) dut (.clock(clock), .reset_n(reset_n), .bus(bus));

    typedef struct {
        logic       ap;
        logic       en;
        logic [7:0] d;
        int         nbits;
        logic       match;
        logic       rw;
        logic       fe;
        logic       nack;
    } vec_t;

    typedef struct {
        logic [7:0] rx;
        logic       match;
        logic       rw;
        logic       fe;
    } rx_exp_t;

    rx_exp_t rxq[$];
    logic    ackq[$];
    int      n_cmp = 0;
    int      n_err = 0;
    logic [7:0] sh_m = 8'h00;
    vec_t    tv[10];

    task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    // One SCL clock per bit; the reader strobes bit_load while SCL is high.
    task automatic send_bits(input logic [7:0] d, input int nbits, input logic fin,
                             input logic m, input logic rw, input logic fe);
        rx_exp_t e;
        for (int i = 0; i < nbits; i++) begin
            bus.scl = 1'b1;
            tick(2);
            bus.bit_data    = d[7-i];
            bus.bit_load    = 1'b1;
            bus.byte_finish = fin && (i == nbits - 1);
            sh_m = {sh_m[6:0], d[7-i]};
            if (bus.byte_finish) begin
                e.rx = sh_m; e.match = m; e.rw = rw; e.fe = fe;
                rxq.push_back(e);
            end
            tick(1);
            bus.bit_load    = 1'b0;
            bus.byte_finish = 1'b0;
            tick(1);
            bus.scl = 1'b0;
            tick(2);
        end
    endtask

    // Ninth SCL clock: SDA is already driven by the time this runs.
    task automatic ack_clock(input logic exp_sda);
        tick(1);
        check("sda_oe_scl_low", bus.sda_oe, exp_sda);
        bus.scl = 1'b1;
        tick(3);
        check("sda_oe_scl_high", bus.sda_oe, exp_sda);
        bus.scl = 1'b0;
        tick(3);
        check("sda_oe_released", bus.sda_oe, 1'b0);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_rx_byte"}, bus.rx_byte, 8'h00);
        check({tag, "_rx_valid"}, bus.rx_valid, 1'b0);
        check({tag, "_addr_match"}, bus.addr_match, 1'b0);
        check({tag, "_rw"}, bus.rw, 1'b0);
        check({tag, "_sda_oe"}, bus.sda_oe, 1'b0);
        check({tag, "_ack_done"}, bus.ack_done, 1'b0);
        check({tag, "_nack"}, bus.nack, 1'b0);
        check({tag, "_frame_error"}, bus.frame_error, 1'b0);
    endtask

    always @(negedge clock) begin
        if (reset_n) begin
            if (bus.rx_valid) begin
                if (rxq.size() == 0) check("rx_unexpected_pulse", bus.rx_valid, 1'b0);
                else begin
                    rx_exp_t e;
                    e = rxq.pop_front();
                    check("rx_byte", bus.rx_byte, e.rx);
                    check("addr_match", bus.addr_match, e.match);
                    check("rw", bus.rw, e.rw);
                    check("frame_error", bus.frame_error, e.fe);
                end
            end
            if (bus.ack_done) begin
                if (ackq.size() == 0) check("ack_done_unexpected", bus.ack_done, 1'b0);
                else check("nack", bus.nack, ackq.pop_front());
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic gc_m, gc_rw, gc_n;
`ifdef I2C_SLAVE_GENERAL_CALL_EN
        gc_m = 1'b1; gc_rw = 1'b0; gc_n = 1'b0;
`else
        gc_m = 1'b0; gc_rw = 1'b1; gc_n = 1'b1;
`endif
        //          ap    en    d      n  match rw    fe    nack
        tv[0] = '{1'b1, 1'b0, 8'hA0, 8, 1'b1, 1'b0, 1'b0, 1'b0};
        tv[1] = '{1'b0, 1'b1, 8'h3C, 8, 1'b1, 1'b0, 1'b0, 1'b0};
        tv[2] = '{1'b0, 1'b0, 8'hFF, 8, 1'b1, 1'b0, 1'b0, 1'b1};
        tv[3] = '{1'b1, 1'b0, 8'hA1, 8, 1'b1, 1'b1, 1'b0, 1'b0};
        tv[4] = '{1'b1, 1'b0, 8'hA3, 8, 1'b0, 1'b1, 1'b0, 1'b1};
        tv[5] = '{1'b0, 1'b1, 8'h55, 8, 1'b0, 1'b1, 1'b0, 1'b1};
        tv[6] = '{1'b1, 1'b0, 8'h00, 8, gc_m, gc_rw, 1'b0, gc_n};
        tv[7] = '{1'b1, 1'b0, 8'hA0, 8, 1'b1, 1'b0, 1'b0, 1'b0};
        tv[8] = '{1'b1, 1'b0, 8'hB0, 5, 1'b1, 1'b0, 1'b1, 1'b0};
        tv[9] = '{1'b0, 1'b1, 8'h3C, 8, 1'b1, 1'b0, 1'b1, 1'b0};

        bus.go = 1'b0; bus.addr_phase = 1'b0; bus.ack_en = 1'b0;
        bus.bit_data = 1'b0; bus.bit_load = 1'b0; bus.byte_finish = 1'b0; bus.scl = 1'b0;
        #1;
        check_reset_vals("reset");
        tick(3);
        reset_n = 1'b1;
        tick(2);
        check_reset_vals("post_reset");
        bus.go = 1'b1;
        tick(2);

        for (int i = 0; i < 10; i++) begin
            bus.addr_phase = tv[i].ap;
            bus.ack_en     = tv[i].en;
            if (tv[i].nbits == 8) ackq.push_back(tv[i].nack);
            send_bits(tv[i].d, tv[i].nbits, 1'b1, tv[i].match, tv[i].rw, tv[i].fe);
            if (tv[i].nbits == 8) ack_clock(~tv[i].nack);
            else check("short_no_sda", bus.sda_oe, 1'b0);
        end

        // go low clears sticky error and match, keeps the last byte
        bus.go = 1'b0;
        tick(1);
        check("go_low_frame_error", bus.frame_error, 1'b0);
        check("go_low_addr_match", bus.addr_match, 1'b0);
        check("go_low_rx_byte_kept", bus.rx_byte, 8'h3C);
        bus.go = 1'b1;
        tick(2);

        // completion coincident with an SCL fall: ACK waits for the next fall
        bus.addr_phase = 1'b1;
        send_bits(8'hA0, 7, 1'b0, 1'b0, 1'b0, 1'b0);
        bus.scl = 1'b1;
        tick(2);
        bus.scl = 1'b0;
        tick(1);
        bus.bit_data = 1'b0; bus.bit_load = 1'b1; bus.byte_finish = 1'b1;
        sh_m = {sh_m[6:0], 1'b0};
        rxq.push_back('{sh_m, 1'b1, 1'b0, 1'b0});
        ackq.push_back(1'b0);
        tick(1);
        bus.bit_load = 1'b0; bus.byte_finish = 1'b0;
        tick(3);
        check("simul_edge_not_consumed", bus.sda_oe, 1'b0);
        bus.scl = 1'b1;
        tick(3);
        bus.scl = 1'b0;
        tick(3);
        check("simul_sda_on_next_fall", bus.sda_oe, 1'b1);
        ack_clock(1'b1);

        // abort in ACK_HIGH: SDA released next clock, no ack_done
        send_bits(8'hA0, 8, 1'b1, 1'b1, 1'b0, 1'b0);
        check("abort_sda_before", bus.sda_oe, 1'b1);
        bus.go = 1'b0;
        tick(1);
        check("abort_sda_released", bus.sda_oe, 1'b0);
        bus.scl = 1'b1;
        tick(3);
        bus.scl = 1'b0;
        tick(3);
        check("abort_addr_match", bus.addr_match, 1'b0);
        check("abort_sda_stays_low", bus.sda_oe, 1'b0);

        // asynchronous reset in the middle of a byte
        bus.go = 1'b1;
        tick(2);
        ackq.push_back(1'b0);
        send_bits(8'hA1, 8, 1'b1, 1'b1, 1'b1, 1'b0);
        ack_clock(1'b1);
        send_bits(8'hFF, 3, 1'b0, 1'b0, 1'b0, 1'b0);
        bus.scl = 1'b1;
        tick(1);
        reset_n = 1'b0;
        #1;
        check_reset_vals("async_reset");
        sh_m = 8'h00;
        tick(2);
        reset_n = 1'b1;
        tick(2);

        check("rx_queue_leftover", 8'(rxq.size()), 8'd0);
        check("ack_queue_leftover", 8'(ackq.size()), 8'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
